// File: rtl/cfg_pkt_arbiter.sv
// Packet-atomic 2:1 AXI-Stream arbiter: config packets win over data (bounded by a burst guard),
// merged beats leave through a 2-entry registered skid buffer toward the pipeline ingress.
module cfg_pkt_arbiter #(
    parameter int DATA_W        = 512,
    parameter int KEEP_W        = 64,
    parameter int USER_W        = 32,
    parameter int CFG_BURST_MAX = 4,
    parameter int CNT_W         = 32
) (
    input  logic              axis_aclk,
    input  logic              axis_rst,

    input  logic [DATA_W-1:0] s_data_tdata,
    input  logic [KEEP_W-1:0] s_data_tkeep,
    input  logic [USER_W-1:0] s_data_tuser,
    input  logic              s_data_tvalid,
    input  logic              s_data_tlast,
    output logic              s_data_tready,

    input  logic [DATA_W-1:0] s_cfg_tdata,
    input  logic [KEEP_W-1:0] s_cfg_tkeep,
    input  logic [USER_W-1:0] s_cfg_tuser,
    input  logic              s_cfg_tvalid,
    input  logic              s_cfg_tlast,
    output logic              s_cfg_tready,

    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic [USER_W-1:0] m_axis_tuser,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,

    input  logic              data_en,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  cnt_data_pkts,
    output logic [CNT_W-1:0]  cnt_cfg_pkts
);

    localparam int BEAT_W  = DATA_W + KEEP_W + USER_W + 1;
    localparam int BURST_W = $clog2(CFG_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(CFG_BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CFG  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [CNT_W-1:0]    cnt_data_q, cnt_data_d;
    logic [CNT_W-1:0]    cnt_cfg_q, cnt_cfg_d;
    logic [1:0]          fill_q, fill_d;
    logic [BEAT_W-1:0]   head_q, head_d;
    logic [BEAT_W-1:0]   skid_q, skid_d;

    logic                live;
    logic                buf_full;
    logic                data_take;
    logic                cfg_take;
    logic                in_push;
    logic                out_pop;
    logic                data_pend;
    logic                cfg_win;
    logic [BEAT_W-1:0]   in_beat;

    // Every output is forced low while reset is asserted, including the cycle before the reset edge.
    assign live     = !axis_rst;
    assign buf_full = (fill_q == 2'd2);

    assign s_data_tready = live && (state_q == ST_DATA) && !buf_full;
    assign s_cfg_tready  = live && (state_q == ST_CFG) && !buf_full;

    assign data_take = s_data_tvalid && s_data_tready;
    assign cfg_take  = s_cfg_tvalid && s_cfg_tready;
    assign in_push   = data_take || cfg_take;
    assign in_beat   = cfg_take ? {s_cfg_tlast, s_cfg_tuser, s_cfg_tkeep, s_cfg_tdata}
                                : {s_data_tlast, s_data_tuser, s_data_tkeep, s_data_tdata};

    assign m_axis_tvalid = live && (fill_q != 2'd0);
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} =
        m_axis_tvalid ? head_q : '0;
    assign out_pop = m_axis_tvalid && m_axis_tready;

    assign grant         = live ? grant_q : 2'b00;
    assign cnt_data_pkts = live ? cnt_data_q : '0;
    assign cnt_cfg_pkts  = live ? cnt_cfg_q : '0;

    always_comb begin
        data_pend  = s_data_tvalid && data_en;
        cfg_win    = s_cfg_tvalid && ((burst_q < BURST_MAX) || !data_pend);
        state_d    = state_q;
        burst_d    = burst_q;
        cnt_data_d = cnt_data_q;
        cnt_cfg_d  = cnt_cfg_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_win) begin
                    state_d = ST_CFG;
                end else if (data_pend) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_take && s_data_tlast) begin
                    state_d    = ST_IDLE;
                    burst_d    = '0;
                    cnt_data_d = cnt_data_q + 1'b1;
                end
            end
            ST_CFG: begin
                if (cfg_take && s_cfg_tlast) begin
                    state_d   = ST_IDLE;
                    cnt_cfg_d = cnt_cfg_q + 1'b1;
                    // The guard only accumulates while data is actually waiting for a grant.
                    if (!data_pend) begin
                        burst_d = '0;
                    end else if (burst_q < BURST_MAX) begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_DATA: grant_d = 2'b01;
            ST_CFG:  grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        fill_d = fill_q;
        case (fill_q)
            2'd0: begin
                if (in_push) begin
                    head_d = in_beat;
                    fill_d = 2'd1;
                end
            end
            2'd1: begin
                if (in_push && out_pop) begin
                    head_d = in_beat;
                end else if (in_push) begin
                    skid_d = in_beat;
                    fill_d = 2'd2;
                end else if (out_pop) begin
                    fill_d = 2'd0;
                end
            end
            default: begin
                // Full: input is already held off, so only the drain side can move.
                if (out_pop) begin
                    head_d = skid_q;
                    fill_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            burst_q    <= '0;
            cnt_data_q <= '0;
            cnt_cfg_q  <= '0;
            fill_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            burst_q    <= burst_d;
            cnt_data_q <= cnt_data_d;
            cnt_cfg_q  <= cnt_cfg_d;
            fill_q     <= fill_d;
        end
    end

    always_ff @(posedge axis_aclk) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

endmodule
